// File: rtl/ec_add_arbiter.sv
// Shares one elliptic-curve point adder between two requesters.
// Each requester owns a one-deep operand slot; the adder is granted round-robin.
module ec_add_arbiter #(
    parameter int unsigned W = 256
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         req0_in_valid,
    input  logic [W-1:0] req0_Px,
    input  logic [W-1:0] req0_Py,
    input  logic [W-1:0] req0_Qx,
    input  logic [W-1:0] req0_Qy,
    output logic [W-1:0] req0_Rx,
    output logic [W-1:0] req0_Ry,
    output logic         req0_out_valid,

    input  logic         req1_in_valid,
    input  logic [W-1:0] req1_Px,
    input  logic [W-1:0] req1_Py,
    input  logic [W-1:0] req1_Qx,
    input  logic [W-1:0] req1_Qy,
    output logic [W-1:0] req1_Rx,
    output logic [W-1:0] req1_Ry,
    output logic         req1_out_valid,

    output logic [W-1:0] add_Px,
    output logic [W-1:0] add_Py,
    output logic [W-1:0] add_Qx,
    output logic [W-1:0] add_Qy,
    output logic         add_in_valid,
    input  logic [W-1:0] add_Rx,
    input  logic [W-1:0] add_Ry,
    input  logic         add_out_valid,

    output logic         busy,
    output logic         err
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e           state_q, state_d;
    logic [1:0]       pending_q, pending_d;
    logic             grant_q, grant_d;
    logic             last_q, last_d;
    logic             err_q, err_d;
    logic [4*W-1:0]   hold_q [2];
    logic [W-1:0]     rx_q [2];
    logic [W-1:0]     ry_q [2];

    logic [1:0]       req_valid;
    logic [4*W-1:0]   req_ops [2];
    logic             drive_ops;

    assign req_valid  = {req1_in_valid, req0_in_valid};
    assign req_ops[0] = {req0_Px, req0_Py, req0_Qx, req0_Qy};
    assign req_ops[1] = {req1_Px, req1_Py, req1_Qx, req1_Qy};

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        grant_d   = grant_q;
        last_d    = last_q;
        err_d     = err_q;

        unique case (state_q)
            StIdle: begin
                if (|pending_q) begin
                    // On a tie the requester not served last time wins.
                    if (pending_q == 2'b11) grant_d = ~last_q;
                    else                    grant_d = pending_q[1];
                    last_d  = grant_d;
                    state_d = StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait:  if (add_out_valid) state_d = StResp;
            StResp: begin
                pending_d[grant_q] = 1'b0;
                state_d            = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (add_out_valid && (state_q != StWait)) err_d = 1'b1;

        // Capture checks the registered pending bit, so a pulse during RESP is dropped.
        for (int n = 0; n < 2; n++) begin
            if (req_valid[n]) begin
                if (pending_q[n]) err_d = 1'b1;
                else              pending_d[n] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pending_q <= 2'b00;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            err_q     <= 1'b0;
            hold_q[0] <= '0;
            hold_q[1] <= '0;
            rx_q[0]   <= '0;
            rx_q[1]   <= '0;
            ry_q[0]   <= '0;
            ry_q[1]   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            err_q     <= err_d;
            for (int n = 0; n < 2; n++) begin
                if (req_valid[n] && !pending_q[n]) hold_q[n] <= req_ops[n];
            end
            if ((state_q == StWait) && add_out_valid) begin
                rx_q[grant_q] <= add_Rx;
                ry_q[grant_q] <= add_Ry;
            end
        end
    end

    assign drive_ops = (state_q == StIssue) || (state_q == StWait);
    assign {add_Px, add_Py, add_Qx, add_Qy} = drive_ops ? hold_q[grant_q] : '0;

    assign add_in_valid   = (state_q == StIssue);
    assign req0_out_valid = (state_q == StResp) && !grant_q;
    assign req1_out_valid = (state_q == StResp) && grant_q;
    assign req0_Rx        = rx_q[0];
    assign req0_Ry        = ry_q[0];
    assign req1_Rx        = rx_q[1];
    assign req1_Ry        = ry_q[1];
    assign busy           = (state_q != StIdle);
    assign err            = err_q;

endmodule
